// File: rtl/fifo_pkg.sv
// Shared types for the FWFT word packer: pack FSM states and lane-count sizing.
package fifo_pkg;

  typedef enum logic [1:0] {
    P_EMPTY,
    P_FILL,
    P_STALL
  } pack_state_e;

  // One extra bit so the counter can hold PACK_RATIO itself (a full pack).
  function automatic int lane_cnt_width(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

endpackage

// File: rtl/fifo_fwft.sv
// Generic first-word-fall-through FIFO: rdata shows the head word whenever empty is low.
// Single-cycle push/pop; a push while full or a pop while empty is ignored.
module fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pack_out_reg.sv
// Single-entry valid/ready output slot; load is only issued when the slot is free,
// so data/keep stay frozen while valid is high and ready is low.
module pack_out_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [KEEP_W-1:0] keep
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      keep  <= load_keep;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_fwft_packer.sv
// Pops narrow FWFT words and packs PACK_RATIO of them (lane 0 first) into one wide beat;
// partial beats leave on flush_i or idle timeout. One beat in the output slot plus one stalled pack.
module fifo_fwft_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata_i,
  output logic                             fifo_ren_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data_o,
  output logic [PACK_RATIO-1:0]            out_keep_o,
  input  logic                             flush_i,
  output logic                             busy_o
);

  localparam int LCW = lane_cnt_width(PACK_RATIO);
  localparam int BW  = DATA_WIDTH * PACK_RATIO;
  localparam int IDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LCW-1:0] LANES_FULL = LCW'(PACK_RATIO);

  pack_state_e       state, state_n;
  logic [LCW-1:0]    lane_cnt, lane_cnt_n, cnt_ins;
  logic [IDW-1:0]    idle_cnt, idle_cnt_n;
  logic              flush_pend, flush_pend_n;
  logic [BW-1:0]     pack, pack_n, pack_ins;
  logic              pop;
  logic              slot_free;
  logic              timeout_hit;
  logic              load;
  logic [BW-1:0]     load_data;
  logic [PACK_RATIO-1:0] load_keep;

  function automatic logic [PACK_RATIO-1:0] keep_mask(input logic [LCW-1:0] n);
    logic [PACK_RATIO-1:0] m;
    for (int k = 0; k < PACK_RATIO; k++) begin
      m[k] = (LCW'(k) < n);
    end
    return m;
  endfunction

  // Pop enable depends only on registered state, never on out_ready_i.
  assign pop         = rst_n && !fifo_empty_i && (state != P_STALL) && !flush_pend;
  assign fifo_ren_o  = pop;
  assign slot_free   = !out_valid_o || out_ready_i;
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == IDW'(TIMEOUT));
  assign busy_o      = (lane_cnt != '0) || out_valid_o;

  always_comb begin
    pack_ins = pack;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if (pop && (lane_cnt == LCW'(k))) begin
        pack_ins[k*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata_i;
      end
    end
    cnt_ins = lane_cnt + {{(LCW-1){1'b0}}, pop};
  end

  always_comb begin
    state_n      = state;
    lane_cnt_n   = lane_cnt;
    idle_cnt_n   = idle_cnt;
    flush_pend_n = flush_pend;
    pack_n       = pack;
    load         = 1'b0;
    load_data    = pack_ins;
    load_keep    = '0;

    case (state)
      P_EMPTY: begin
        if (pop) begin
          state_n    = P_FILL;
          pack_n     = pack_ins;
          lane_cnt_n = cnt_ins;
          idle_cnt_n = '0;
        end
      end

      P_FILL: begin
        if (flush_pend) begin
          if (slot_free) begin
            load      = 1'b1;
            load_data = pack;
            load_keep = keep_mask(lane_cnt);
          end
        end else if (pop && (cnt_ins == LANES_FULL)) begin
          if (slot_free) begin
            load      = 1'b1;
            load_keep = '1;
          end else begin
            state_n    = P_STALL;
            pack_n     = pack_ins;
            lane_cnt_n = cnt_ins;
            idle_cnt_n = '0;
          end
        end else if (flush_i || (!pop && timeout_hit)) begin
          // A word popped alongside flush_i rides in the flushed beat.
          if (slot_free) begin
            load      = 1'b1;
            load_keep = keep_mask(cnt_ins);
          end else begin
            flush_pend_n = 1'b1;
            pack_n       = pack_ins;
            lane_cnt_n   = cnt_ins;
            idle_cnt_n   = '0;
          end
        end else if (pop) begin
          pack_n     = pack_ins;
          lane_cnt_n = cnt_ins;
          idle_cnt_n = '0;
        end else begin
          idle_cnt_n = idle_cnt + 1'b1;
        end
      end

      P_STALL: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = pack;
          load_keep = '1;
        end
      end

      default: state_n = P_EMPTY;
    endcase

    if (load) begin
      state_n      = P_EMPTY;
      lane_cnt_n   = '0;
      idle_cnt_n   = '0;
      flush_pend_n = 1'b0;
      pack_n       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= P_EMPTY;
      lane_cnt   <= '0;
      idle_cnt   <= '0;
      flush_pend <= 1'b0;
      pack       <= '0;
    end else begin
      state      <= state_n;
      lane_cnt   <= lane_cnt_n;
      idle_cnt   <= idle_cnt_n;
      flush_pend <= flush_pend_n;
      pack       <= pack_n;
    end
  end

  pack_out_reg #(
    .DATA_W (BW),
    .KEEP_W (PACK_RATIO)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .ready     (out_ready_i),
    .valid     (out_valid_o),
    .data      (out_data_o),
    .keep      (out_keep_o)
  );

endmodule

// File: tb/tb_fifo_fwft_packer.sv
// Bench: a fifo_fwft source feeds the packer; accepted beats are scored against expected packs.
module tb_fifo_fwft_packer;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int PR = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          src_rst_n;
  logic          push;
  logic [DW-1:0] push_data;
  logic          src_full;
  logic [4:0]    src_count;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_ren;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [3:0]    out_keep;
  logic          flush;
  logic          busy;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  logic [31:0] exp_data[$];
  logic [3:0]  exp_keep[$];

  always #5 clk = ~clk;

  fifo_fwft #(.WIDTH(DW), .DEPTH(16)) u_src (
    .clk(clk), .rst_n(src_rst_n), .push(push), .push_data(push_data),
    .pop(fifo_ren), .rdata(fifo_rdata), .empty(fifo_empty), .full(src_full),
    .count(src_count)
  );

  fifo_fwft_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty_i(fifo_empty), .fifo_rdata_i(fifo_rdata),
    .fifo_ren_o(fifo_ren), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_keep_o(out_keep), .flush_i(flush), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_word(input logic [7:0] b);
    push = 1'b1;
    push_data = b;
    tick();
    push = 1'b0;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k);
    exp_data.push_back(d);
    exp_keep.push_back(k);
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n = 0;
    while (!(busy === 1'b0 && fifo_empty === 1'b1 && exp_data.size() == 0) && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < max_cyc), 64'd1);
  endtask

  // Scoreboard: every beat accepted downstream must be the next expected pack.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (exp_data.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed=%0h expected=none", out_data);
      end
      if (exp_data.size() != 0) begin
        chk("beat_data", out_data, exp_data.pop_front());
        chk("beat_keep", out_keep, exp_keep.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] gdata;
    int          glen;
    logic [7:0]  b;

    rst_n = 1'b0; src_rst_n = 1'b0;
    push = 1'b0; push_data = '0; out_ready = 1'b1; flush = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ren", fifo_ren, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; src_rst_n = 1'b1;
    tick();

    // Streaming: one pop per cycle, last word popped one edge after the last push.
    expect_beat(32'h04030201, 4'hF);
    expect_beat(32'h08070605, 4'hF);
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    tick();
    chk("stream_valid", out_valid, 1);
    chk("stream_data2", out_data, 32'h08070605);
    chk("stream_drained", fifo_empty, 1);
    wait_idle(20, "stream_idle");

    // Backpressure: one beat held, one pack stalled, remainder left in the source.
    out_ready = 1'b0;
    expect_beat(32'h04030201, 4'hF);
    expect_beat(32'h08070605, 4'hF);
    expect_beat(32'h0C0B0A09, 4'hF);
    for (int i = 1; i <= 12; i++) push_word(8'(i));
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 32'h04030201);
    chk("bp_state", dut.state, P_STALL);
    chk("bp_src_count", src_count, 4);
    chk("bp_ren_blocked", fifo_ren, 0);
    repeat (3) tick();
    chk("bp_hold_data", out_data, 32'h04030201);
    chk("bp_hold_keep", out_keep, 4'hF);
    out_ready = 1'b1;
    wait_idle(40, "bp_drain");

    // Idle timeout: beat becomes valid TO+1 cycles after the last pop.
    expect_beat(32'h0000BBAA, 4'h3);
    push_word(8'hAA);
    push_word(8'hBB);
    tick();
    repeat (TO) tick();
    chk("timeout_early", out_valid, 0);
    tick();
    chk("timeout_valid", out_valid, 1);
    chk("timeout_data", out_data, 32'h0000BBAA);
    chk("timeout_keep", out_keep, 4'h3);
    wait_idle(10, "timeout_idle");

    // Explicit flush of a 3-lane pack, then a flush with nothing packed.
    expect_beat(32'h00332211, 4'h7);
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_valid", out_valid, 1);
    chk("flush_data", out_data, 32'h00332211);
    chk("flush_keep", out_keep, 4'h7);
    wait_idle(10, "flush_idle");
    flush = 1'b1; tick(); flush = 1'b0; tick();
    chk("flush_empty_valid", out_valid, 0);
    chk("flush_empty_busy", busy, 0);

    // Flush coinciding with the pop of the fourth word: one full beat only.
    expect_beat(32'h44332211, 4'hF);
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("simul_valid", out_valid, 1);
    chk("simul_data", out_data, 32'h44332211);
    chk("simul_keep", out_keep, 4'hF);
    tick();
    chk("simul_single", out_valid, 0);
    chk("simul_busy", busy, 0);

    // Flush while the slot is occupied: pops blocked until the held beat leaves.
    out_ready = 1'b0;
    expect_beat(32'h04030201, 4'hF);
    expect_beat(32'h00005B5A, 4'h3);
    expect_beat(32'h0000005C, 4'h1);
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    push_word(8'h5A); push_word(8'h5B);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    push_word(8'h5C);
    chk("pend_ren_blocked", fifo_ren, 0);
    chk("pend_src_count", src_count, 1);
    tick();
    chk("pend_ren_still", fifo_ren, 0);
    chk("pend_hold_data", out_data, 32'h04030201);
    out_ready = 1'b1;
    tick();
    chk("pend_beat_data", out_data, 32'h00005B5A);
    chk("pend_ren_resume", fifo_ren, 1);
    repeat (3) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    wait_idle(20, "pend_idle");

    // Reset mid-pack: partial pack dropped, words waiting in the source not popped.
    push_word(8'h01); push_word(8'h02);
    tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    push_word(8'h05);
    chk("mid_rst_ren", fifo_ren, 0);
    push_word(8'h06); push_word(8'h07); push_word(8'h08);
    chk("mid_rst_src", src_count, 4);
    expect_beat(32'h08070605, 4'hF);
    rst_n = 1'b1;
    wait_idle(20, "mid_rst_idle");

    // Random groups of 1..4 words with random ready; short groups close by flush or timeout.
    rand_ready = 1'b1;
    for (int g = 0; g < 30; g++) begin
      glen = $urandom_range(1, 4);
      gdata = '0;
      for (int i = 0; i < glen; i++) begin
        b = 8'($urandom_range(0, 255));
        gdata = gdata | (32'(b) << (8 * i));
      end
      expect_beat(gdata, 4'((1 << glen) - 1));
      for (int i = 0; i < glen; i++) begin
        push_word(gdata[8*i +: 8]);
        repeat ($urandom_range(0, 3)) tick();
      end
      for (int n = 0; n < 20 && fifo_empty !== 1'b1; n++) tick();
      repeat (2) tick();
      if (glen < 4 && $urandom_range(0, 1) == 1) begin
        flush = 1'b1; tick(); flush = 1'b0;
      end
      wait_idle(100, "rand_group");
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    chk("rand_queue_empty", exp_data.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_fwft_packer.md
# fifo_fwft_packer

Read-side consumer for the team's first-word-fall-through FIFO (`fifo_fwft`). It pops DATA_WIDTH words whenever the FIFO is non-empty and packs PACK_RATIO of them into one wide beat. Beats are presented on a valid/ready stream. Partial beats carry a lane-keep mask and are emitted on an idle timeout or an explicit flush. The block sits between the narrow FIFO and wide downstream logic.

## Interface
Parameters:
- DATA_WIDTH, 8, FIFO word width (bits)
- PACK_RATIO, 4, FIFO words per output beat; legal range ≥ 2
- TIMEOUT, 16, idle cycles before a partial beat is flushed; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fifo_empty_i  in  1  FIFO empty flag; when low, fifo_rdata_i holds the head word (FWFT)
- fifo_rdata_i  in  DATA_WIDTH  FIFO head word
- fifo_ren_o  out  1  pop strobe; the head word is consumed at this clock edge
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accept
- out_data_o  out  DATA_WIDTH*PACK_RATIO  packed beat; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
- out_keep_o  out  PACK_RATIO  lane valid mask for out_data_o
- flush_i  in  1  single-cycle request to emit the current partial pack
- busy_o  out  1  high when the pack is non-empty or out_valid_o is high

## Operation
- Lane order: the first popped word goes to lane 0 (little-endian). Unfilled lanes are driven 0 with their keep bits 0.
- Pack FSM:
  - P_EMPTY: lane_cnt = 0.
  - P_FILL: 0 < lane_cnt < PACK_RATIO.
  - P_STALL: pack is complete, waiting for the output slot.
- Definitions:
  - slot_free = !out_valid_o || out_ready_i
  - fifo_ren_o = !fifo_empty_i && state != P_STALL && !flush_pend
  - fifo_ren_o has no combinational path from out_ready_i.
- Pop of the last lane:
  - If slot_free: transfer the pack to the output register with keep all ones, then go to P_EMPTY.
  - Otherwise: go to P_STALL.
- P_STALL: when slot_free, transfer, then go to P_EMPTY.
- Partial flush triggers (only in P_FILL):
  - flush_i = 1.
  - Idle counter reaches TIMEOUT. The counter increments on each P_FILL cycle without a pop and clears on every pop and on every transfer.
- Partial flush response:
  - If slot_free: transfer with keep = (1<<lane_cnt)-1, then go to P_EMPTY.
  - Otherwise: set flush_pend. While flush_pend is set, pops are blocked; the transfer happens when slot_free.
- Simultaneous events:
  - flush_i and a pop in the same cycle: the popped word is included in the flushed beat.
  - A pop in the same cycle the timeout would fire: the pop wins and the counter clears.
  - flush_i in P_EMPTY: ignored.
  - flush_i in P_STALL: no effect; the full beat is already pending.
- Output register: out_data_o and out_keep_o are held stable while out_valid_o && !out_ready_i. A new beat may load in the same cycle the old beat is accepted.
- Reset (asynchronous) state:
  - State P_EMPTY; lane_cnt, idle counter and flush_pend cleared.
  - Pack register and out_data_o = 0; out_keep_o = 0; out_valid_o = 0.
  - fifo_ren_o = 0 while rst_n is low; busy_o = 0.

## Timing
- Latency: out_valid_o rises 1 cycle after the edge that pops the last lane or that samples the flush/timeout condition.
- Throughput: one pop per cycle while the FIFO is non-empty and the output drains. This gives one beat per PACK_RATIO cycles sustained.
- Under backpressure, at most one beat is held in the output register and one full pack is held in P_STALL. Further words stay in the FIFO.
- Timeout: with TIMEOUT=T, a partial beat becomes valid T+1 cycles after the last pop.

## Structure
- Package fifo_pkg:
  - pack_state_e {P_EMPTY, P_FILL, P_STALL}
  - lane-count width constant $clog2(PACK_RATIO)+1
- Sub-module pack_out_reg: a single-entry valid/ready output register holding data and keep, with a load strobe, parameterised by width. Everything else (FSM, lane counter, idle counter) lives in the top module.

## Test plan
All scenarios use DATA_WIDTH=8, PACK_RATIO=4, TIMEOUT=16, with a fifo_fwft instance as the source.
- Stream: push 0x01..0x08 with out_ready_i=1 -> beats 0x04030201 then 0x08070605, keep 0xF, one pop per cycle.
- Backpressure: push 0x01..0x0C with out_ready_i=0 -> beat 0x04030201 held stable; FSM reaches P_STALL with 0x08070605; bytes 0x09..0x0C remain in the FIFO (count 4). Raise ready -> three beats in order, no loss or duplication.
- Timeout: push 0xAA, 0xBB then idle -> 17 cycles after the last pop, out_data_o=0x0000BBAA, out_keep_o=0x3.
- Flush: push 0x11, 0x22, 0x33 then pulse flush_i -> next cycle 0x00332211, keep 0x7. A flush_i pulse with an empty pack -> no beat.
- Simultaneous: flush_i in the same cycle as the pop of 0x44 after 0x11, 0x22, 0x33 -> a single beat 0x44332211, keep 0xF. Flush with ready=0 -> pops blocked until the beat is accepted.
- Reset mid-operation: pack 2 bytes, then assert rst_n low -> out_valid_o=0, busy_o=0, fifo_ren_o=0. After release, bytes 0x05..0x08 -> 0x08070605 with no stale lanes.
